// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - run/stop/step control with read/write wait states and timeout fault
module exec_sequencer #(
    parameter int                 INSTR_W     = 16,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = INSTR_W'(16'h0300),
    parameter int                 READ_LAT    = 1,
    parameter int                 WRITE_LAT   = 1,
    parameter int                 TIMEOUT     = 255,
    parameter int                 CNT_W       = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run_btn,
    input  logic               step_mode,
    input  logic               halt_req,
    input  logic [INSTR_W-1:0] instr,
    input  logic               dec_increment,
    input  logic [1:0]         dec_load_src,
    input  logic               dec_store_mem,
    input  logic               dec_store_stk,
    input  logic               mem_ready,
    output logic               pc_increment,
    output logic [1:0]         load_src,
    output logic               store_mem,
    output logic               store_stk,
    output logic               running,
    output logic               fault,
    output logic [CNT_W-1:0]   retired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW:0]   RD_NEED = (CW + 1)'(READ_LAT);
    localparam logic [CW:0]   WR_NEED = (CW + 1)'(WRITE_LAT);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_STOPPED,
        ST_ARMED,
        ST_RUN,
        ST_RD_WAIT,
        ST_WR_WAIT,
        ST_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic        needs_read, needs_write, to_stop;
    logic [CW:0] cnt_inc;
    logic        rd_done, wr_done, timed_out;
    logic        retire;
    logic [1:0]  load_src_c;
    logic        store_mem_c, store_stk_c;

    assign needs_read  = dec_load_src[1];
    assign needs_write = dec_store_mem | dec_store_stk;
    assign to_stop     = halt_req | step_mode | (instr == HALT_OPCODE);

    // cnt_inc is the number of cycles spent in the wait state including this one
    assign cnt_inc   = {1'b0, cnt_q} + (CW + 1)'(1);
    assign rd_done   = (cnt_inc >= RD_NEED) && mem_ready;
    assign wr_done   = (cnt_inc >= WR_NEED) && mem_ready;
    assign timed_out = (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        retire      = 1'b0;
        load_src_c  = 2'b00;
        store_mem_c = 1'b0;
        store_stk_c = 1'b0;
        case (state_q)
            ST_STOPPED: if (!run_btn) state_d = ST_ARMED;
            ST_ARMED:   if (run_btn)  state_d = ST_RUN;
            ST_RUN: begin
                if (needs_read) begin
                    state_d = ST_RD_WAIT;
                end else if (needs_write) begin
                    state_d = ST_WR_WAIT;
                end else begin
                    retire     = 1'b1;
                    load_src_c = dec_load_src;
                end
            end
            ST_RD_WAIT: begin
                if (rd_done) begin
                    load_src_c = dec_load_src;
                    if (needs_write) state_d = ST_WR_WAIT;
                    else             retire  = 1'b1;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            ST_WR_WAIT: begin
                if (wr_done) begin
                    store_mem_c = dec_store_mem;
                    store_stk_c = dec_store_stk;
                    retire      = 1'b1;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_STOPPED;
        endcase
        if (retire) state_d = to_stop ? ST_STOPPED : ST_RUN;
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_STOPPED;
            cnt_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
        end
    end

    // Outputs are forced low while reset is high so an aborted transfer never strobes
    assign pc_increment = !reset && retire && dec_increment;
    assign load_src     = reset ? 2'b00 : load_src_c;
    assign store_mem    = !reset && store_mem_c;
    assign store_stk    = !reset && store_stk_c;
    assign running      = !reset && (state_q == ST_RUN || state_q == ST_RD_WAIT ||
                                     state_q == ST_WR_WAIT);
    assign fault        = !reset && (state_q == ST_FAULT);
    assign retired      = reset ? '0 : retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed table, corner sequences and random run against a reference model
module tb_exec_sequencer;

    localparam int RL   = 3;
    localparam int WL   = 2;
    localparam int TO   = 8;
    localparam int CNTW = 4;
    localparam logic [15:0] HALT = 16'h0300;
    localparam logic [15:0] ALU  = 16'h1234;

    localparam int MS_STOP = 0;
    localparam int MS_ARM  = 1;
    localparam int MS_ACT  = 2;
    localparam int MS_FLT  = 3;

    logic            clock = 1'b0;
    logic            reset, run_btn, step_mode, halt_req;
    logic [15:0]     instr;
    logic            dec_increment;
    logic [1:0]      dec_load_src;
    logic            dec_store_mem, dec_store_stk, mem_ready;
    logic            pc_increment;
    logic [1:0]      load_src;
    logic            store_mem, store_stk, running, fault;
    logic [CNTW-1:0] retired;

    exec_sequencer #(
        .INSTR_W(16), .HALT_OPCODE(HALT), .READ_LAT(RL), .WRITE_LAT(WL),
        .TIMEOUT(TO), .CNT_W(CNTW)
    ) dut (
        .clock(clock), .reset(reset), .run_btn(run_btn), .step_mode(step_mode),
        .halt_req(halt_req), .instr(instr), .dec_increment(dec_increment),
        .dec_load_src(dec_load_src), .dec_store_mem(dec_store_mem),
        .dec_store_stk(dec_store_stk), .mem_ready(mem_ready),
        .pc_increment(pc_increment), .load_src(load_src), .store_mem(store_mem),
        .store_stk(store_stk), .running(running), .fault(fault), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          rst, run, step, halt;
        logic [15:0] ins;
        bit          inc;
        logic [1:0]  src;
        bit          sm, ss, rdy;
        bit          e_pc;
        logic [1:0]  e_src;
        bit          e_sm, e_ss, e_run, e_flt;
        int          e_ret;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    int m_mode = MS_STOP, m_phase = 0, m_waited = 0, m_ret = 0;
    int n_mode, n_phase, n_waited, n_ret;
    int exp_pc, exp_src, exp_sm, exp_ss, exp_run, exp_flt, exp_ret;

    vec_t tbl[25];

    function automatic vec_t mk(input bit rst, run, step, halt, input logic [15:0] ins,
                                input bit inc, input logic [1:0] src, input bit sm, ss, rdy,
                                input bit epc, input logic [1:0] esrc,
                                input bit esm, ess, erun, eflt, input int eret);
        vec_t v;
        v.rst = rst; v.run = run; v.step = step; v.halt = halt; v.ins = ins;
        v.inc = inc; v.src = src; v.sm = sm; v.ss = ss; v.rdy = rdy;
        v.e_pc = epc; v.e_src = esrc; v.e_sm = esm; v.e_ss = ess;
        v.e_run = erun; v.e_flt = eflt; v.e_ret = eret;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst; run_btn = v.run; step_mode = v.step; halt_req = v.halt;
        instr = v.ins; dec_increment = v.inc; dec_load_src = v.src;
        dec_store_mem = v.sm; dec_store_stk = v.ss; mem_ready = v.rdy;
    endtask

    // Reference: an instruction is decoded, optionally spends cycles in a read and/or
    // write transfer, then retires; m_waited counts transfer cycles already completed.
    task automatic model_eval();
        bit done;
        int lat;
        done = 1'b0;
        n_mode = m_mode; n_phase = m_phase; n_waited = m_waited; n_ret = m_ret;
        exp_pc = 0; exp_src = 0; exp_sm = 0; exp_ss = 0; exp_run = 0; exp_flt = 0;
        exp_ret = m_ret;
        if (reset) begin
            n_mode = MS_STOP; n_phase = 0; n_waited = 0; n_ret = 0; exp_ret = 0;
        end else begin
            case (m_mode)
                MS_STOP: if (!run_btn) n_mode = MS_ARM;
                MS_ARM: if (run_btn) begin n_mode = MS_ACT; n_phase = 0; n_waited = 0; end
                MS_FLT: exp_flt = 1;
                default: begin
                    exp_run = 1;
                    if (m_phase == 0) begin
                        if (dec_load_src[1]) begin
                            n_phase = 1; n_waited = 0;
                        end else if (dec_store_mem || dec_store_stk) begin
                            n_phase = 2; n_waited = 0;
                        end else begin
                            done = 1'b1; exp_src = int'(dec_load_src);
                        end
                    end else begin
                        lat = (m_phase == 1) ? RL : WL;
                        if (m_waited + 1 >= lat && mem_ready) begin
                            if (m_phase == 1) begin
                                exp_src = int'(dec_load_src);
                                if (dec_store_mem || dec_store_stk) begin
                                    n_phase = 2; n_waited = 0;
                                end else begin
                                    done = 1'b1;
                                end
                            end else begin
                                exp_sm = int'(dec_store_mem);
                                exp_ss = int'(dec_store_stk);
                                done   = 1'b1;
                            end
                        end else if (m_waited + 1 >= TO) begin
                            n_mode = MS_FLT;
                        end else begin
                            n_waited = m_waited + 1;
                        end
                    end
                    if (done) begin
                        exp_pc  = int'(dec_increment);
                        n_ret   = (m_ret + 1) % (1 << CNTW);
                        n_phase = 0; n_waited = 0;
                        if (halt_req || step_mode || instr == HALT) n_mode = MS_STOP;
                    end
                end
            endcase
        end
    endtask

    task automatic eval_check();
        @(negedge clock);
        model_eval();
        chk("pc_increment", int'(pc_increment), exp_pc);
        chk("load_src", int'(load_src), exp_src);
        chk("store_mem", int'(store_mem), exp_sm);
        chk("store_stk", int'(store_stk), exp_ss);
        chk("running", int'(running), exp_run);
        chk("fault", int'(fault), exp_flt);
        chk("retired", int'(retired), exp_ret);
    endtask

    task automatic commit();
        @(posedge clock);
        m_mode = n_mode; m_phase = n_phase; m_waited = n_waited; m_ret = n_ret;
        #1;
    endtask

    task automatic step();
        eval_check();
        commit();
    endtask

    initial begin
        // rst run stp hlt instr inc src sm ss rdy | pc src sm ss run flt ret
        tbl[0]  = mk(1,1,0,0,ALU ,1,2'b01,0,0,1, 0,2'b00,0,0,0,0,0);
        tbl[1]  = mk(0,0,0,0,ALU ,1,2'b01,0,0,1, 0,2'b00,0,0,0,0,0);
        tbl[2]  = mk(0,0,0,0,ALU ,1,2'b01,0,0,1, 0,2'b00,0,0,0,0,0);
        tbl[3]  = mk(0,1,0,0,ALU ,1,2'b01,0,0,1, 0,2'b00,0,0,0,0,0);
        tbl[4]  = mk(0,1,0,0,ALU ,1,2'b01,0,0,1, 1,2'b01,0,0,1,0,0);
        tbl[5]  = mk(0,1,0,0,ALU ,1,2'b01,0,0,1, 1,2'b01,0,0,1,0,1);
        tbl[6]  = mk(0,1,0,0,ALU ,1,2'b01,0,0,1, 1,2'b01,0,0,1,0,2);
        tbl[7]  = mk(0,1,0,0,ALU ,1,2'b01,0,0,1, 1,2'b01,0,0,1,0,3);
        tbl[8]  = mk(0,1,0,0,ALU ,1,2'b01,0,0,1, 1,2'b01,0,0,1,0,4);
        tbl[9]  = mk(0,1,0,0,ALU ,1,2'b10,0,0,1, 0,2'b00,0,0,1,0,5);
        tbl[10] = mk(0,1,0,0,ALU ,1,2'b10,0,0,1, 0,2'b00,0,0,1,0,5);
        tbl[11] = mk(0,1,0,0,ALU ,1,2'b10,0,0,1, 0,2'b00,0,0,1,0,5);
        tbl[12] = mk(0,1,0,0,ALU ,1,2'b10,0,0,1, 1,2'b10,0,0,1,0,5);
        tbl[13] = mk(0,1,0,0,ALU ,1,2'b11,0,1,1, 0,2'b00,0,0,1,0,6);
        tbl[14] = mk(0,1,0,0,ALU ,1,2'b11,0,1,1, 0,2'b00,0,0,1,0,6);
        tbl[15] = mk(0,1,0,0,ALU ,1,2'b11,0,1,1, 0,2'b00,0,0,1,0,6);
        tbl[16] = mk(0,1,0,0,ALU ,1,2'b11,0,1,1, 0,2'b11,0,0,1,0,6);
        tbl[17] = mk(0,1,0,0,ALU ,1,2'b11,0,1,1, 0,2'b00,0,0,1,0,6);
        tbl[18] = mk(0,1,0,0,ALU ,1,2'b11,0,1,1, 1,2'b00,0,1,1,0,6);
        tbl[19] = mk(0,1,0,0,HALT,0,2'b00,0,0,1, 0,2'b00,0,0,1,0,7);
        tbl[20] = mk(0,1,0,0,ALU ,1,2'b01,0,0,1, 0,2'b00,0,0,0,0,8);
        tbl[21] = mk(0,1,0,0,ALU ,1,2'b01,0,0,1, 0,2'b00,0,0,0,0,8);
        tbl[22] = mk(0,0,0,0,ALU ,1,2'b01,0,0,1, 0,2'b00,0,0,0,0,8);
        tbl[23] = mk(0,1,0,0,ALU ,1,2'b01,0,0,1, 0,2'b00,0,0,0,0,8);
        tbl[24] = mk(0,1,0,0,ALU ,1,2'b01,0,0,1, 1,2'b01,0,0,1,0,8);

        apply(tbl[0]);
        for (int i = 0; i < 25; i++) begin
            apply(tbl[i]);
            eval_check();
            chk($sformatf("tbl%0d_pc", i), int'(pc_increment), int'(tbl[i].e_pc));
            chk($sformatf("tbl%0d_src", i), int'(load_src), int'(tbl[i].e_src));
            chk($sformatf("tbl%0d_sm", i), int'(store_mem), int'(tbl[i].e_sm));
            chk($sformatf("tbl%0d_ss", i), int'(store_stk), int'(tbl[i].e_ss));
            chk($sformatf("tbl%0d_run", i), int'(running), int'(tbl[i].e_run));
            chk($sformatf("tbl%0d_flt", i), int'(fault), int'(tbl[i].e_flt));
            chk($sformatf("tbl%0d_ret", i), int'(retired), tbl[i].e_ret);
            commit();
        end

        // Timeout: read never acknowledged, fault is sticky until reset
        apply(mk(0,1,0,0,ALU,1,2'b10,0,0,0, 0,0,0,0,0,0,0));
        for (int i = 0; i < 9; i++) step();
        eval_check();
        chk("fault_latched", int'(fault), 1);
        chk("fault_no_retire", int'(retired), 9);
        commit();
        for (int i = 0; i < 4; i++) begin
            run_btn = (i % 2 == 0) ? 1'b0 : 1'b1;
            mem_ready = 1'b1;
            eval_check();
            chk("fault_hold", int'(fault), 1);
            chk("fault_not_running", int'(running), 0);
            commit();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_btn = 1'b1;
        eval_check();
        chk("fault_cleared", int'(fault), 0);
        chk("reset_retired", int'(retired), 0);
        commit();

        // Single-step: three button presses give three retires
        apply(mk(0,1,1,0,ALU,1,2'b01,0,0,1, 0,0,0,0,0,0,0));
        for (int k = 0; k < 3; k++) begin
            run_btn = 1'b0; step();
            run_btn = 1'b1; step();
            eval_check();
            chk("step_pc", int'(pc_increment), 1);
            commit();
            eval_check();
            chk("step_stopped", int'(running), 0);
            commit();
        end
        eval_check();
        chk("step_retired", int'(retired), 3);
        commit();

        // Random run against the model
        reset = 1'b1;
        step();
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            run_btn   = ($urandom_range(0, 2) != 0);
            step_mode = ($urandom_range(0, 7) == 0);
            halt_req  = ($urandom_range(0, 15) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            if (!(m_mode == MS_ACT && m_phase != 0)) begin
                instr         = ($urandom_range(0, 15) == 0) ? HALT : 16'($urandom);
                dec_increment = ($urandom_range(0, 1) == 1);
                dec_load_src  = 2'($urandom_range(0, 3));
                dec_store_mem = ($urandom_range(0, 3) == 0);
                dec_store_stk = ($urandom_range(0, 3) == 0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Parametrised execution sequencer: run/stop/single-step control plus memory wait-state handling between the instruction decoder and the datapath.
- Gates the decoder's program-counter increment, load-source and store strobes so each instruction retires exactly once.
- Inserts a configurable number of read and write wait states per instruction, qualified by a memory ready handshake with a timeout fault.
- Sits between the instruction decoder and the register file/memory/stack load-store logic.

Parameters:
INSTR_W, 16, instruction width
HALT_OPCODE, 16'h0300, instruction value that stops execution after it retires
READ_LAT, 1, minimum wait cycles in RD_WAIT (1..15)
WRITE_LAT, 1, minimum wait cycles in WR_WAIT (1..15)
TIMEOUT, 255, maximum cycles in one wait state before FAULT (must be greater than READ_LAT and WRITE_LAT)
CNT_W, 16, width of retired-instruction counter

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high reset
run_btn  in  1  user run button, level, active high
step_mode  in  1  1 = single-step: return to STOPPED after each retire
halt_req  in  1  external stop request (clock lock / switch clock)
instr  in  INSTR_W  current instruction
dec_increment  in  1  decoder PC-increment request
dec_load_src  in  2  decoder load source (00 self, 01 alu, 10 mem, 11 stk)
dec_store_mem  in  1  decoder store to memory
dec_store_stk  in  1  decoder store to stack
mem_ready  in  1  memory/stack transfer complete
pc_increment  out  1  PC advance strobe
load_src  out  2  gated load source
store_mem  out  1  gated memory write strobe
store_stk  out  1  gated stack write strobe
running  out  1  state is RUN, RD_WAIT or WR_WAIT
fault  out  1  timeout fault latched
retired  out  CNT_W  instructions retired since reset

Behaviour:
- Reset: state STOPPED; wait counter 0; retired 0; fault 0. All outputs are 0 during reset and in the cycle after reset deasserts.
- needs_read = dec_load_src[1]; needs_write = dec_store_mem | dec_store_stk.
- to_stop = halt_req | step_mode | (instr == HALT_OPCODE).
- States: STOPPED, ARMED, RUN, RD_WAIT, WR_WAIT, FAULT.
- STOPPED: go to ARMED when run_btn = 0, else stay. This requires release before a new start.
- ARMED: go to RUN when run_btn = 1.
- RUN, with the decision taken on entry to each new instruction:
  - needs_read -> RD_WAIT;
  - else needs_write -> WR_WAIT;
  - else retire this cycle, then go to STOPPED if to_stop, else stay in RUN.
- RD_WAIT:
  - The counter increments every cycle starting from 0 on entry.
  - Exit when counter >= READ_LAT-1 and mem_ready = 1. In that exit cycle load_src = dec_load_src.
  - On exit: needs_write -> WR_WAIT (counter cleared); else retire, then STOPPED if to_stop, else RUN.
- WR_WAIT:
  - Same counting, using WRITE_LAT.
  - store_mem/store_stk follow the decoder strobes for exactly the exit cycle only (one-cycle pulse).
  - That cycle is a retire cycle; next state is STOPPED if to_stop, else RUN.
- Timeout: if the counter reaches TIMEOUT-1 in any wait state without exit -> FAULT.
  - No retire and no strobes in that cycle.
  - fault = 1 and stays 1 until reset. FAULT ignores every input except reset.
- Retire cycle:
  - pc_increment = dec_increment.
  - retired increments by 1 and wraps to 0 after all ones.
  - A retire occurs even when dec_increment = 0 (e.g. jump/halt).
- Gating: outside the cycles above, load_src = 00, store_mem = store_stk = 0 and pc_increment = 0.
  - In RUN without a wait, load_src = dec_load_src in the retire cycle.
- halt_req sampled mid-wait does not abort the transfer; it takes effect at that instruction's retire.
- Inputs instr/dec_* must be held stable by the datapath from entering a wait state until retire. The sequencer does not register them.
- Reset mid-wait: state returns to STOPPED next edge. No strobe is issued during that cycle.

Test Plan:
- Reset then run_btn 0 -> 1, with instr = ALU op, no load/store, dec_increment = 1, step_mode = 0 -> RUN; pc_increment = 1 every cycle; retired = 5 after 5 cycles.
- READ_LAT = 3, dec_load_src = 10, mem_ready tied to 1 -> pc_increment and load_src = 10 asserted once, on the 3rd RD_WAIT cycle; load_src = 00 on the first 2.
- Read followed by store: dec_load_src = 11, dec_store_stk = 1, WRITE_LAT = 2 -> RD_WAIT exit, then WR_WAIT; store_stk is a single-cycle pulse on the 2nd WR_WAIT cycle; retired increments once.
- mem_ready held 0 in RD_WAIT with TIMEOUT = 8 -> FAULT after 8 cycles; fault = 1; no retire; run_btn toggling has no effect; reset clears fault to 0.
- instr = 16'h0300 in RUN -> one retire, then STOPPED; running = 0; a restart requires run_btn 0 then 1.
- step_mode = 1, run_btn pulsed three times (each 0 -> 1) -> exactly 3 retires; state is STOPPED between pulses.
